// File: rtl/gp_adder_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit add/subtract unit between NUM_REQ requesters.
// Accepted operations return through a single registered response slot tagged with the requester index.
module gp_adder_arbiter #(
  parameter int WIDTH   = 64,
  parameter int NUM_REQ = 4,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       i_req_valid,
  input  logic [NUM_REQ-1:0]       i_req_sub,
  input  logic [NUM_REQ*WIDTH-1:0] i_req_a,
  input  logic [NUM_REQ*WIDTH-1:0] i_req_b,
  output logic [NUM_REQ-1:0]       o_req_ready,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [WIDTH-1:0]         o_rsp_sum,
  output logic [ID_W-1:0]          o_rsp_id
);

  logic [ID_W-1:0]  r_prio;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_sum;
  logic [ID_W-1:0]  r_rsp_id;

  logic             w_slot_free;
  logic             w_gnt_any;
  logic [ID_W-1:0]  w_gnt_id;
  logic             w_xfer;
  logic [ID_W-1:0]  w_prio_nxt;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b_raw;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_sum;

  assign w_slot_free = !r_rsp_valid || i_rsp_ready;
  // Reset gates the grant so req_ready drops the instant rst_n falls.
  assign w_xfer      = rst_n && w_slot_free && w_gnt_any;

  // Round-robin scan: walk offsets from farthest to nearest so the requester closest to prio wins.
  always_comb begin
    int v_idx;
    w_gnt_any = 1'b0;
    w_gnt_id  = {ID_W{1'b0}};
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      v_idx = (int'(r_prio) + k) % NUM_REQ;
      if (i_req_valid[v_idx]) begin
        w_gnt_any = 1'b1;
        w_gnt_id  = v_idx[ID_W-1:0];
      end else begin
        w_gnt_any = w_gnt_any;
      end
    end
  end

  // One-hot ready for the granted requester, only when a transfer actually happens.
  always_comb begin
    o_req_ready = {NUM_REQ{1'b0}};
    if (w_xfer) begin
      o_req_ready[w_gnt_id] = 1'b1;
    end else begin
      o_req_ready = {NUM_REQ{1'b0}};
    end
  end

  // Operand mux and two's-complement negate for subtract; carry-out is dropped.
  always_comb begin
    w_a     = i_req_a[int'(w_gnt_id)*WIDTH +: WIDTH];
    w_b_raw = i_req_b[int'(w_gnt_id)*WIDTH +: WIDTH];
    if (i_req_sub[w_gnt_id]) begin
      w_b = ~w_b_raw + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      w_b = w_b_raw;
    end
    w_sum = w_a + w_b;
  end

  // Pointer advances to the requester after the one just granted, wrapping at NUM_REQ-1.
  always_comb begin
    if (w_gnt_id == ID_W'(NUM_REQ - 1)) begin
      w_prio_nxt = {ID_W{1'b0}};
    end else begin
      w_prio_nxt = w_gnt_id + ID_W'(1);
    end
  end

  // Response slot and priority pointer; a drain plus a new transfer keeps the slot full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio      <= {ID_W{1'b0}};
      r_rsp_valid <= 1'b0;
      r_rsp_sum   <= {WIDTH{1'b0}};
      r_rsp_id    <= {ID_W{1'b0}};
    end else if (w_xfer) begin
      r_prio      <= w_prio_nxt;
      r_rsp_valid <= 1'b1;
      r_rsp_sum   <= w_sum;
      r_rsp_id    <= w_gnt_id;
    end else if (r_rsp_valid && i_rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end else begin
      r_rsp_valid <= r_rsp_valid;
    end
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_sum   = r_rsp_sum;
  assign o_rsp_id    = r_rsp_id;

endmodule

// File: tb/tb_gp_adder_arbiter.sv
// Directed bench for gp_adder_arbiter: handshake, rotation, pointer skip, arithmetic edges,
// backpressure and asynchronous reset, all against hand-computed values.
module tb_gp_adder_arbiter;
  localparam int WIDTH   = 64;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                     clk;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_sub;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [WIDTH-1:0]         rsp_sum;
  logic [ID_W-1:0]          rsp_id;

  int n_checks;
  int n_fail;

  gp_adder_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req_valid (req_valid),
    .i_req_sub   (req_sub),
    .i_req_a     (req_a),
    .i_req_b     (req_b),
    .o_req_ready (req_ready),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_sum   (rsp_sum),
    .o_rsp_id    (rsp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [63:0] a, input logic [63:0] b, input logic sub);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
    req_sub[i] = sub;
  endtask

  initial begin
    logic [3:0] exp_rdy;
    int g;
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    req_valid = 4'b0000;
    req_sub   = 4'b0000;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;

    // Reset state
    tick();
    tick();
    check("rst_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_ready", {60'd0, req_ready}, 64'd0);
    check("rst_sum",   rsp_sum, 64'd0);
    check("rst_id",    {62'd0, rsp_id}, 64'd0);
    rst_n = 1'b1;
    tick();

    // Single request from requester 0: 5 + 7
    set_op(0, 64'd5, 64'd7, 1'b0);
    req_valid = 4'b0001;
    #1;
    check("single_ready", {60'd0, req_ready}, 64'h1);
    tick();
    req_valid = 4'b0000;
    check("single_valid", {63'd0, rsp_valid}, 64'd1);
    check("single_sum",   rsp_sum, 64'd12);
    check("single_id",    {62'd0, rsp_id}, 64'd0);

    // Arithmetic edges on requesters 1..3 (prio is now 1, slot drains and refills)
    set_op(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    req_valid = 4'b0010;
    #1;
    check("wrap_ready", {60'd0, req_ready}, 64'h2);
    tick();
    req_valid = 4'b0000;
    check("wrap_sum", rsp_sum, 64'd0);
    check("wrap_id",  {62'd0, rsp_id}, 64'd1);

    set_op(2, 64'd3, 64'd5, 1'b1);
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b0000;
    check("sub_neg_sum", rsp_sum, 64'hFFFF_FFFF_FFFF_FFFE);
    check("sub_neg_id",  {62'd0, rsp_id}, 64'd2);

    set_op(3, 64'd9, 64'd0, 1'b1);
    req_valid = 4'b1000;
    tick();
    req_valid = 4'b0000;
    check("sub_zero_sum", rsp_sum, 64'd9);
    check("sub_zero_id",  {62'd0, rsp_id}, 64'd3);

    // Drain with no new request
    tick();
    check("drain_valid", {63'd0, rsp_valid}, 64'd0);

    // Full-load rotation from prio 0: grants 0,1,2,3,0,1,2 back to back
    for (int i = 0; i < NUM_REQ; i++) set_op(i, 64'(100 + i), 64'(i), 1'b0);
    req_valid = 4'b1111;
    for (int k = 0; k < 7; k++) begin
      g = k % NUM_REQ;
      exp_rdy = 4'b0001 << g;
      #1;
      check($sformatf("rot_ready_%0d", k), {60'd0, req_ready}, {60'd0, exp_rdy});
      tick();
      check($sformatf("rot_valid_%0d", k), {63'd0, rsp_valid}, 64'd1);
      check($sformatf("rot_id_%0d", k),    {62'd0, rsp_id}, 64'(g));
      check($sformatf("rot_sum_%0d", k),   rsp_sum, 64'(100 + 2 * g));
    end

    // Pointer skip: last grant was 2, only 1 and 3 valid -> 3 then 1
    req_valid = 4'b1010;
    #1;
    check("skip_ready_a", {60'd0, req_ready}, 64'h8);
    tick();
    check("skip_id_a", {62'd0, rsp_id}, 64'd3);
    #1;
    check("skip_ready_b", {60'd0, req_ready}, 64'h2);
    tick();
    check("skip_id_b",  {62'd0, rsp_id}, 64'd1);
    check("skip_sum_b", rsp_sum, 64'd102);

    // Backpressure: slot holds id 1 / 102, prio is 2
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("bp_ready_%0d", k), {60'd0, req_ready}, 64'd0);
      tick();
      check($sformatf("bp_valid_%0d", k), {63'd0, rsp_valid}, 64'd1);
      check($sformatf("bp_sum_%0d", k),   rsp_sum, 64'd102);
      check($sformatf("bp_id_%0d", k),    {62'd0, rsp_id}, 64'd1);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_ready", {60'd0, req_ready}, 64'h4);
    tick();
    rsp_ready = 1'b0;
    check("bp_release_id",  {62'd0, rsp_id}, 64'd2);
    check("bp_release_sum", rsp_sum, 64'd104);

    // Reset mid-operation (prio 3, slot full), asserted away from any clock edge
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {63'd0, rsp_valid}, 64'd0);
    check("mid_rst_ready", {60'd0, req_ready}, 64'd0);
    check("mid_rst_sum",   rsp_sum, 64'd0);
    tick();
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    #1;
    check("post_rst_ready", {60'd0, req_ready}, 64'h1);
    tick();
    check("post_rst_id",  {62'd0, rsp_id}, 64'd0);
    check("post_rst_sum", rsp_sum, 64'd100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
